key_conditioner: RTL and testbench

Parametrised multi-channel front-end for the board's push-buttons and switches (KEY, SW), replacing ad-hoc `~KEY` reset/input wiring. Each channel is synchronised and debounced. It reports a clean level plus single-cycle press, release and long-press pulses to the core and to the reset/menu logic. All channels are independent; one clock domain.

---
 rtl/key_conditioner.sv | 172 +++++++++++++++++
 tb/tb_key_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Multi-channel push-button / switch front-end: polarity fix, synchroniser,
// debounce FSM and registered level / press / release / long-press outputs.
module key_conditioner #(
  parameter int CHANNELS        = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                clk_50,
  input  logic                reset_50,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [CHANNELS-1:0] POLARITY = (ACTIVE_LOW != 0) ? '1 : '0;

  // Bit 1 of the encoding is the debounced level, which the output logic relies on.
  typedef enum logic [1:0] {
    ST_UP      = 2'b00,
    ST_DB_DOWN = 2'b01,
    ST_DOWN    = 2'b10,
    ST_DB_UP   = 2'b11
  } state_e;

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  s_in;
  logic [CHANNELS-1:0]                  s;

  state_e            state_q  [CHANNELS];
  state_e            state_d  [CHANNELS];
  logic [DB_W-1:0]   db_cnt_q [CHANNELS];
  logic [DB_W-1:0]   db_cnt_d [CHANNELS];
  logic [HOLD_W-1:0] hold_q   [CHANNELS];
  logic [HOLD_W-1:0] hold_d   [CHANNELS];

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pressed_q, pressed_d;
  logic [CHANNELS-1:0] released_q, released_d;
  logic [CHANNELS-1:0] long_press_q, long_press_d;

  assign s_in = raw ^ POLARITY;

  always_comb begin
    sync_d = sync_q;
    s      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], s_in[c]};
      s[c]      = sync_q[c][SYNC_STAGES-1];
    end
  end

  // State register
  always_ff @(posedge clk_50) begin
    if (reset_50) begin
      sync_q       <= '0;
      level_q      <= '0;
      pressed_q    <= '0;
      released_q   <= '0;
      long_press_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= ST_UP;
        db_cnt_q[c] <= '0;
        hold_q[c]   <= '0;
      end
    end else begin
      sync_q       <= sync_d;
      level_q      <= level_d;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      long_press_q <= long_press_d;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= state_d[c];
        db_cnt_q[c] <= db_cnt_d[c];
        hold_q[c]   <= hold_d[c];
      end
    end
  end

  // Next-state logic; DEBOUNCE_CYCLES == 1 skips the DB_* states entirely.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]  = state_q[c];
      db_cnt_d[c] = db_cnt_q[c];
      case (state_q[c])
        ST_UP: begin
          if (s[c]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[c] = ST_DOWN;
            end else begin
              state_d[c]  = ST_DB_DOWN;
              db_cnt_d[c] = DB_W'(1);
            end
          end
        end
        ST_DB_DOWN: begin
          if (!s[c]) begin
            state_d[c]  = ST_UP;
            db_cnt_d[c] = '0;
          end else if (db_cnt_q[c] >= DB_LAST) begin
            state_d[c]  = ST_DOWN;
            db_cnt_d[c] = '0;
          end else begin
            db_cnt_d[c] = db_cnt_q[c] + 1'b1;
          end
        end
        ST_DOWN: begin
          if (!s[c]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[c] = ST_UP;
            end else begin
              state_d[c]  = ST_DB_UP;
              db_cnt_d[c] = DB_W'(1);
            end
          end
        end
        ST_DB_UP: begin
          if (s[c]) begin
            state_d[c]  = ST_DOWN;
            db_cnt_d[c] = '0;
          end else if (db_cnt_q[c] >= DB_LAST) begin
            state_d[c]  = ST_UP;
            db_cnt_d[c] = '0;
          end else begin
            db_cnt_d[c] = db_cnt_q[c] + 1'b1;
          end
        end
        default: begin
          state_d[c]  = ST_UP;
          db_cnt_d[c] = '0;
        end
      endcase

      // Hold count starts at 0 on acceptance, runs through DB_UP, saturates.
      if (!state_d[c][1] || !state_q[c][1]) begin
        hold_d[c] = '0;
      end else if (hold_q[c] == HOLD_MAX) begin
        hold_d[c] = hold_q[c];
      end else begin
        hold_d[c] = hold_q[c] + 1'b1;
      end
    end
  end

  // Output logic: pulses are level transitions of the next state.
  always_comb begin
    level_d      = '0;
    pressed_d    = '0;
    released_d   = '0;
    long_press_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      level_d[c]      = state_d[c][1];
      pressed_d[c]    = state_d[c][1] && !state_q[c][1];
      released_d[c]   = !state_d[c][1] && state_q[c][1];
      long_press_d[c] = (LONG_CYCLES > 0) && state_d[c][1] &&
                        (hold_d[c] == HOLD_MAX) && (hold_q[c] != HOLD_MAX);
    end
  end

  assign level      = level_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign long_press = long_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: an active-low and an active-high instance
// see the same logical stimulus and must produce identical, hand-derived traces.
module tb_key_conditioner;

  localparam int NMAX = 64;

  // Clock / reset
  logic       clk_50 = 1'b0;
  logic       reset_50;
  logic [1:0] raw_a, raw_b;
  logic [1:0] level_a, pressed_a, released_a, long_a;
  logic [1:0] level_b, pressed_b, released_b, long_b;

  always #10 clk_50 = ~clk_50;

  key_conditioner #(
    .CHANNELS(2), .ACTIVE_LOW(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)
  ) dut_a (
    .clk_50(clk_50), .reset_50(reset_50), .raw(raw_a),
    .level(level_a), .pressed(pressed_a), .released(released_a), .long_press(long_a)
  );

  key_conditioner #(
    .CHANNELS(2), .ACTIVE_LOW(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)
  ) dut_b (
    .clk_50(clk_50), .reset_50(reset_50), .raw(raw_b),
    .level(level_b), .pressed(pressed_b), .released(released_b), .long_press(long_b)
  );

  // Plan for one scenario: stim[k] = asserted channels sampled at edge k,
  // exp_arr[k] = {long_press, released, pressed, level} visible after edge k.
  logic [1:0]  stim    [NMAX];
  logic [7:0]  exp_arr [NMAX];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam int K_PRESS   = 1;
  localparam int K_RELEASE = 2;
  localparam int K_LONG    = 3;

  // Driver tasks
  task automatic clear_plan();
    for (int k = 0; k < NMAX; k++) begin
      stim[k]    = 2'b00;
      exp_arr[k] = 8'h00;
    end
  endtask

  task automatic hold_in(input int ch, input int from, input int to);
    for (int k = from; k <= to; k++) stim[k][ch] = 1'b1;
  endtask

  task automatic exp_level(input int ch, input int from, input int to);
    for (int k = from; k <= to; k++) exp_arr[k][ch] = 1'b1;
  endtask

  task automatic exp_pulse(input int kind, input int ch, input int at);
    exp_arr[at][kind*2+ch] = 1'b1;
  endtask

  task automatic drive(input logic [1:0] asserted, input logic rst);
    reset_50 = rst;
    raw_a    = ~asserted;
    raw_b    = asserted;
  endtask

  // Scoreboard: pop the expectation pushed with this edge's stimulus.
  task automatic check_step(input string tag, input int k);
    logic [15:0] obs_v, exp_v;
    @(posedge clk_50);
    #1;
    obs_v = {long_b, released_b, pressed_b, level_b, long_a, released_a, pressed_a, level_a};
    exp_v = exp_q.pop_front();
    n_cmp++;
    assert (obs_v === exp_v)
      else begin
        n_bad++;
        $error("FAIL %s edge %0d: observed %h expected %h", tag, k, obs_v, exp_v);
      end
  endtask

  task automatic reset_step(input string tag, input logic [1:0] held);
    drive(held, 1'b1);
    exp_q.push_back(16'h0000);
    check_step({tag, "_reset"}, 0);
  endtask

  task automatic run_plan(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      drive(stim[k], 1'b0);
      exp_q.push_back({exp_arr[k], exp_arr[k]});
      check_step(tag, k);
    end
  endtask

  initial begin
    int n_hold;
    drive(2'b00, 1'b1);

    // Clean press on ch0, held for a random while past the long-press point.
    reset_step("clean", 2'b00);
    n_hold = 20 + $urandom_range(0, 10);
    clear_plan();
    hold_in(0, 1, n_hold);
    exp_level(0, 6, n_hold);
    exp_pulse(K_PRESS, 0, 6);
    exp_pulse(K_LONG, 0, 16);
    run_plan("clean", n_hold);

    // Bounce: 3 low, 1 high, then low; acceptance counts from edge 5.
    reset_step("bounce", 2'b00);
    clear_plan();
    hold_in(0, 1, 3);
    hold_in(0, 5, 25);
    exp_level(0, 10, 25);
    exp_pulse(K_PRESS, 0, 10);
    exp_pulse(K_LONG, 0, 20);
    run_plan("bounce", 25);

    // Release glitch of 2 samples is absorbed; later a clean release.
    reset_step("glitch", 2'b00);
    clear_plan();
    hold_in(0, 1, 11);
    hold_in(0, 14, 40);
    exp_level(0, 6, 45);
    exp_pulse(K_PRESS, 0, 6);
    exp_pulse(K_LONG, 0, 16);
    exp_pulse(K_RELEASE, 0, 46);
    run_plan("glitch", 55);

    // Channel 1 starts one cycle after channel 0.
    reset_step("stagger", 2'b00);
    clear_plan();
    hold_in(0, 1, 20);
    hold_in(1, 2, 20);
    exp_level(0, 6, 20);
    exp_level(1, 7, 20);
    exp_pulse(K_PRESS, 0, 6);
    exp_pulse(K_PRESS, 1, 7);
    exp_pulse(K_LONG, 0, 16);
    exp_pulse(K_LONG, 1, 17);
    run_plan("stagger", 20);

    // Reset while both levels are 1 and ch0 stays held: no release, full re-press.
    reset_step("midhold", 2'b01);
    clear_plan();
    hold_in(0, 1, 12);
    exp_level(0, 6, 12);
    exp_pulse(K_PRESS, 0, 6);
    run_plan("midhold", 12);

    // Simultaneous press and release on both channels.
    reset_step("simul", 2'b00);
    clear_plan();
    hold_in(0, 1, 12);
    hold_in(1, 1, 12);
    exp_level(0, 6, 17);
    exp_level(1, 6, 17);
    exp_pulse(K_PRESS, 0, 6);
    exp_pulse(K_PRESS, 1, 6);
    exp_pulse(K_LONG, 0, 16);
    exp_pulse(K_LONG, 1, 16);
    exp_pulse(K_RELEASE, 0, 18);
    exp_pulse(K_RELEASE, 1, 18);
    run_plan("simul", 22);

    n_cmp++;
    assert (exp_q.size() === 0)
      else begin
        n_bad++;
        $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
      end

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
